// File: rtl/instr_mem_slave.sv
// rtl/instr_mem_slave.sv - instruction ROM responder for the fetch stage (req/ack/last, flush, stall)
// Optional IMEM_ERR_CHECK_EN: misaligned or out-of-program addresses return NOP with o_err.
module instr_mem_slave #(
  parameter int    IWIDTH    = 32,
  parameter int    AWIDTH    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter int    PROG_LEN  = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              f_clk,
  input  logic              f_rst,
  input  logic              i_syn,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [IWIDTH-1:0] o_instr,
  output logic              o_ack,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_err
);

  localparam int                IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]     LAST_IDX = IW'(PROG_LEN - 1);
  localparam logic [IWIDTH-1:0] NOP      = IWIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [IW-1:0]     r_idx;
  logic              r_bad;
  logic [IWIDTH-1:0] r_instr;
  logic              r_ack;
  logic              r_last;
  logic              r_busy;
  logic [IWIDTH-1:0] r_rom [DEPTH];

  logic [IW-1:0]     w_idx;
  logic              w_bad;
  logic [IW-1:0]     w_src_idx;
  logic              w_src_bad;
  logic [IWIDTH-1:0] w_word;
  logic              w_word_last;
  logic              w_accept;
  logic              w_respond;

  initial begin
    for (int i = 0; i < DEPTH; i++) r_rom[i] = '0;
  end

  assign w_idx = i_addr[IW+1:2];

`ifdef IMEM_ERR_CHECK_EN
  logic r_err;
  assign w_bad = (i_addr[1:0] != 2'b00) || (i_addr[AWIDTH-1:2] >= (AWIDTH-2)'(PROG_LEN));
  assign o_err = r_err;
`else
  logic w_unused;
  assign w_bad    = 1'b0;
  assign o_err    = 1'b0;
  assign w_unused = ^{i_addr[1:0], i_addr[AWIDTH-1:IW+2]};
`endif

  // A response is built either from the latched request (WAIT) or straight from the bus (LATENCY==1).
  assign w_src_idx   = (r_state == S_WAIT) ? r_idx : w_idx;
  assign w_src_bad   = (r_state == S_WAIT) ? r_bad : w_bad;
  assign w_word      = w_src_bad ? NOP : r_rom[w_src_idx];
  assign w_word_last = !w_src_bad && (w_src_idx == LAST_IDX);

  assign w_accept  = i_syn && !i_flush &&
                     ((r_state == S_IDLE) || ((r_state == S_RESP) && !r_last));
  assign w_respond = ((r_state == S_WAIT) && !i_flush && !i_stall && (r_cnt == 4'd0)) ||
                     (w_accept && (LATENCY == 1));

  // r_cnt holds the number of further unstalled WAIT cycles before the response edge.
  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_bad   <= 1'b0;
      r_instr <= '0;
      r_ack   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef IMEM_ERR_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ack  <= 1'b0;
      r_last <= 1'b0;
`ifdef IMEM_ERR_CHECK_EN
      r_err  <= 1'b0;
`endif
      if (w_accept && (LATENCY > 1)) begin
        r_idx   <= w_idx;
        r_bad   <= w_bad;
        r_cnt   <= 4'(LATENCY - 2);
        r_state <= S_WAIT;
        r_busy  <= 1'b1;
      end else if (w_respond) begin
        r_instr <= w_word;
        r_ack   <= 1'b1;
        r_last  <= w_word_last;
`ifdef IMEM_ERR_CHECK_EN
        r_err   <= w_src_bad;
`endif
        r_state <= S_RESP;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (i_flush) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (!i_stall) begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_RESP: begin
            r_state <= (r_last && !i_flush) ? S_DONE : S_IDLE;
            r_busy  <= 1'b0;
          end
          S_DONE: begin
            if (i_flush) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_instr = r_instr;
  assign o_ack   = r_ack;
  assign o_last  = r_last;
  assign o_busy  = r_busy;

endmodule
